// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-RAM frame reader: default image geometry,
// data RAM depth and the reader FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int unsigned IMG_W_DEF  = 360;
  localparam int unsigned IMG_H_DEF  = 360;
  localparam int unsigned DMEM_DEPTH = 129600;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DRAIN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/dmem_frame_reader_if.sv
// -----------------------------------------------------------------------------
// dmem_frame_reader_if
// Bundles the data-RAM read port and the outgoing pixel stream of the frame
// reader.
//   mem_addr   word address to the RAM asynchronous read port
//   mem_rd     RAM read data, combinational from mem_addr
//   out_valid  / out_ready   stream handshake
//   out_pixel  pixel value
//   out_sol / out_eol / out_last   start-of-line, end-of-line, end-of-frame
// Modports: master = frame reader, slave = RAM + stream consumer side.
// -----------------------------------------------------------------------------
interface dmem_frame_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PIX_W  = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W-1:0]  out_pixel;
  logic              out_sol;
  logic              out_eol;
  logic              out_last;

  modport master (
    output mem_addr,
    input  mem_rd,
    output out_valid,
    input  out_ready,
    output out_pixel,
    output out_sol,
    output out_eol,
    output out_last
  );

  modport slave (
    input  mem_addr,
    output mem_rd,
    input  out_valid,
    output out_ready,
    input  out_pixel,
    input  out_sol,
    input  out_eol,
    input  out_last
  );

endinterface

// File: rtl/dmem_frame_reader_start_sync.sv
// -----------------------------------------------------------------------------
// start_sync
// Brings the raw start switch into the clock domain and turns every level
// change (rising or falling) into a single-cycle start event.
//   clk           clock, posedge
//   rst           asynchronous active-high reset
//   switch_start  raw asynchronous switch level
//   start_evt     one-cycle pulse per switch level change
// -----------------------------------------------------------------------------
module start_sync (
  input  logic clk,
  input  logic rst,
  input  logic switch_start,
  output logic start_evt
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      // stage 0/1: metastability filter; stage 2: previous synchronized level
      sync_p0 <= switch_start;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  // Both edges of the switch request a frame.
  assign start_evt = sync_p1 ^ hist_p2;

endmodule

// File: rtl/dmem_frame_reader.sv
// -----------------------------------------------------------------------------
// dmem_frame_reader
// Scans IMG_W*IMG_H consecutive data-RAM words starting at BASE_ADDR and
// streams the low PIX_W bits of each word as one pixel, with line and frame
// markers, one pixel per cycle when the consumer is ready.
//   clk           clock, posedge
//   rst           asynchronous active-high reset
//   switch_start  raw start switch; every level change requests one frame
//   bus           master side of dmem_frame_reader_if (RAM read port + stream)
//   busy          high while a frame is being streamed or drained
//   done          one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module dmem_frame_reader
  import dmem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       IMG_W     = IMG_W_DEF,
  parameter int unsigned       IMG_H     = IMG_H_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       PIX_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                switch_start,
  dmem_frame_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             start_evt;
  logic             load;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             px_last;
  logic             unused_rd;

  start_sync u_start_sync (
    .clk          (clk),
    .rst          (rst),
    .switch_start (switch_start),
    .start_evt    (start_evt)
  );

  assign accept   = bus.out_valid && bus.out_ready;
  // The output register refills whenever it is empty or being emptied this
  // cycle, which gives full throughput and a stable beat under backpressure.
  assign load     = (state == RD_STREAM) && (!bus.out_valid || bus.out_ready);
  assign col_last = (col == COL_W'(IMG_W - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));
  assign px_last  = col_last && row_last;
  assign busy     = (state != RD_IDLE);
  assign unused_rd = ^bus.mem_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A request coinciding with the done pulse belongs to the frame that
      // just ended and is dropped.
      RD_IDLE:   if (start_evt && !done) state_nxt = RD_STREAM;
      RD_STREAM: if (load && px_last)    state_nxt = RD_DRAIN;
      RD_DRAIN:  if (accept)             state_nxt = RD_IDLE;
      default:                           state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= BASE_ADDR;
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_sol   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_last  <= 1'b0;
      col           <= '0;
      row           <= '0;
      done          <= 1'b0;
    end else begin
      done <= (state == RD_DRAIN) && accept;
      case (state)
        RD_IDLE: begin
          col          <= '0;
          row          <= '0;
          bus.mem_addr <= BASE_ADDR;
        end
        RD_STREAM: begin
          if (load) begin
            // output register stage: capture the word addressed this cycle
            bus.out_pixel <= bus.mem_rd[PIX_W-1:0];
            bus.out_valid <= 1'b1;
            bus.out_sol   <= (col == '0);
            bus.out_eol   <= col_last;
            bus.out_last  <= px_last;
            if (col_last) begin
              col <= '0;
              row <= row_last ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            // Parking on the final word keeps the address inside the frame.
            if (!px_last) begin
              bus.mem_addr <= bus.mem_addr + 1'b1;
            end
          end
        end
        RD_DRAIN: begin
          if (accept) begin
            bus.out_valid <= 1'b0;
            bus.out_sol   <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.mem_addr  <= BASE_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_dmem_frame_reader
// Directed bench for dmem_frame_reader. Instance A uses a 40x30 frame at
// address 0 (large enough for mid-frame events, short enough to run many
// frames); instance B uses a 4x3 frame at address 100. Both RAM models return
// the address as data, so beat k of a frame carries pixel (BASE+k) mod 256.
// -----------------------------------------------------------------------------
module tb_dmem_frame_reader;

  localparam int AW = 40;
  localparam int AH = 30;
  localparam int AN = AW * AH;
  localparam int BN = 12;

  logic clk = 1'b0;
  logic rst;
  logic sw_a, sw_b;
  logic busy_a, done_a, busy_b, done_b;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_frame_reader_if #(.ADDR_W(32), .PIX_W(8)) ifa ();
  dmem_frame_reader_if #(.ADDR_W(32), .PIX_W(8)) ifb ();

  assign ifa.mem_rd = ifa.mem_addr;
  assign ifb.mem_rd = ifb.mem_addr;

  dmem_frame_reader #(
    .ADDR_W(32), .IMG_W(AW), .IMG_H(AH), .BASE_ADDR(32'd0), .PIX_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .switch_start(sw_a), .bus(ifa.master),
    .busy(busy_a), .done(done_a)
  );

  dmem_frame_reader #(
    .ADDR_W(32), .IMG_W(4), .IMG_H(3), .BASE_ADDR(32'd100), .PIX_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .switch_start(sw_b), .bus(ifb.master),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Stream monitors on the falling edge: a beat seen valid&&ready here is
  // accepted at the next rising edge.
  int k_a = 0, beats_a = 0, pix_err_a = 0, flag_err_a = 0, addr_err_a = 0;
  int done_cnt_a = 0, done_k_a = 0;

  always @(negedge clk) begin
    if (rst) begin
      k_a = 0;
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (ifa.out_pixel !== 8'(k_a))                 pix_err_a++;
        if (ifa.out_sol  !== ((k_a % AW) == 0))        flag_err_a++;
        if (ifa.out_eol  !== ((k_a % AW) == AW - 1))   flag_err_a++;
        if (ifa.out_last !== (k_a == AN - 1))          flag_err_a++;
        k_a++;
        beats_a++;
      end
      if (done_a) begin
        done_cnt_a++;
        done_k_a = k_a;
        k_a = 0;
      end
      if (ifa.mem_addr > 32'(AN - 1)) addr_err_a++;
    end
  end

  int k_b = 0, beats_b = 0, pix_err_b = 0, done_cnt_b = 0, max_addr_b = 0;
  logic [BN-1:0] sol_m, eol_m, last_m;

  always @(negedge clk) begin
    if (rst) begin
      k_b    = 0;
      sol_m  = '0;
      eol_m  = '0;
      last_m = '0;
    end else begin
      if (ifb.out_valid && ifb.out_ready) begin
        if (ifb.out_pixel !== 8'(100 + k_b)) pix_err_b++;
        if (k_b < BN) begin
          sol_m[k_b]  = ifb.out_sol;
          eol_m[k_b]  = ifb.out_eol;
          last_m[k_b] = ifb.out_last;
        end
        k_b++;
        beats_b++;
      end
      if (done_b) begin
        done_cnt_b++;
        k_b = 0;
      end
      if (int'(ifb.mem_addr) > max_addr_b) max_addr_b = int'(ifb.mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  int s_pix, s_flag, s_addr, s_beats, s_done;

  task automatic start_frame_a(input string tag);
    int n;
    int busy_n;
    s_pix   = pix_err_a;
    s_flag  = flag_err_a;
    s_addr  = addr_err_a;
    s_beats = beats_a;
    s_done  = done_cnt_a;
    @(posedge clk); #1;
    sw_a = ~sw_a;
    n = 0;
    busy_n = 0;
    while (!ifa.out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (busy_a && busy_n == 0) busy_n = n;
    end
    chk({tag, "_valid_lat"}, n, 4);
    chk({tag, "_busy_lat"}, busy_n, 3);
  endtask

  task automatic finish_frame_a(input string tag);
    int n;
    n = 0;
    while (!done_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (n < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_pix_err"},  pix_err_a - s_pix, 0);
    chk({tag, "_flag_err"}, flag_err_a - s_flag, 0);
    chk({tag, "_addr_err"}, addr_err_a - s_addr, 0);
    chk({tag, "_beats"},    beats_a - s_beats, AN);
    chk({tag, "_done_cnt"}, done_cnt_a - s_done, 1);
    chk({tag, "_done_k"},   done_k_a, AN);
    chk({tag, "_idle"},     busy_a, 0);
    chk({tag, "_addr_home"}, ifa.mem_addr, 0);
  endtask

  task automatic wait_beats_a(input string tag, input int target);
    int n;
    n = 0;
    while ((beats_a - s_beats) < target && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_reach_beat"}, (n < 3000), 1);
  endtask

  initial begin
    int n;
    logic hold_ok;
    rst = 1'b1;
    sw_a = 1'b0;
    sw_b = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    #2;
    chk("rst_valid_a", ifa.out_valid, 0);
    chk("rst_addr_a",  ifa.mem_addr, 0);
    chk("rst_pix_a",   ifa.out_pixel, 0);
    chk("rst_busy_a",  busy_a, 0);
    chk("rst_done_a",  done_a, 0);
    chk("rst_addr_b",  ifb.mem_addr, 100);
    chk("rst_flags_b", {ifb.out_sol, ifb.out_eol, ifb.out_last}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_start", busy_a, 0);

    // Full frame with a 5-cycle stall on beat 10.
    start_frame_a("t1");
    n = 0;
    while (!(ifa.out_valid && ifa.out_pixel == 8'd10) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t2_found_beat10", (n < 200), 1);
    ifa.out_ready = 1'b0;
    hold_ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!(ifa.out_valid && ifa.out_pixel == 8'd10 && ifa.mem_addr == 32'd11)) hold_ok = 1'b0;
    end
    chk("t2_hold_stable", hold_ok, 1);
    chk("t2_hold_pixel", ifa.out_pixel, 10);
    chk("t2_hold_addr",  ifa.mem_addr, 11);
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_next_pixel", ifa.out_pixel, 11);
    chk("t2_next_valid", ifa.out_valid, 1);
    finish_frame_a("t1");

    // Switch change mid-frame must not restart or queue a frame.
    start_frame_a("t3");
    wait_beats_a("t3", 1000);
    sw_a = ~sw_a;
    finish_frame_a("t3");
    repeat (10) @(posedge clk);
    #1;
    chk("t3_no_restart_busy",  busy_a, 0);
    chk("t3_no_restart_valid", ifa.out_valid, 0);

    // Asynchronous reset mid-frame, then a clean restart from pixel 0.
    start_frame_a("t4");
    wait_beats_a("t4", 500);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_valid", ifa.out_valid, 0);
    chk("t4_rst_addr",  ifa.mem_addr, 0);
    chk("t4_rst_busy",  busy_a, 0);
    sw_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t4_post_rst_idle", busy_a, 0);
    start_frame_a("t4r");
    finish_frame_a("t4r");

    // Two spaced level changes give two frames.
    repeat (20) @(posedge clk);
    start_frame_a("t6a");
    finish_frame_a("t6a");
    repeat (20) @(posedge clk);
    start_frame_a("t6b");
    finish_frame_a("t6b");

    // Small geometry with offset base address.
    @(posedge clk); #1;
    sw_b = 1'b1;
    n = 0;
    while (!ifb.out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_valid_lat", n, 4);
    chk("t5_first_addr", ifb.mem_addr, 101);
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_done_seen", (n < 100), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_beats",    beats_b, BN);
    chk("t5_pix_err",  pix_err_b, 0);
    chk("t5_sol_mask", sol_m, 12'h111);
    chk("t5_eol_mask", eol_m, 12'h888);
    chk("t5_last_mask", last_m, 12'h800);
    chk("t5_max_addr", max_addr_b, 111);
    chk("t5_done_cnt", done_cnt_b, 1);
    chk("t5_addr_home", ifb.mem_addr, 100);
    chk("t5_idle", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
